sched_bus: RTL and testbench

Parametrised phase scheduler with memory-bus handshake for the next-generation CPU core.
- Replaces the fixed four-phase round-robin scheduler: sequences FETCH, EXEC, MEM and WRITEBACK.
- Adds per-phase wait states and a ready handshake, skips MEM when the instruction does not need it, supports run and single-step modes, and detects bus timeouts.
- Sits between the instruction decoder and the memory bus. Its phase strobes gate the IC, register-file, flag and memory-data enables exactly as the old phase signals did.

---
 rtl/sched_bus_if.sv | 9 +
 rtl/sched_bus.sv | 128 ++++++++++++
 tb/tb_sched_bus.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_bus_if.sv
// rtl/sched_bus_if.sv - memory-bus handshake between the phase scheduler and the memory side.
interface sched_bus_if;
    logic bus_req;
    logic bus_ready;
    logic bus_err;

    modport master (output bus_req, output bus_err, input bus_ready);
    modport slave  (input bus_req, input bus_err, output bus_ready);
endinterface

// File: rtl/sched_bus.sv
// rtl/sched_bus.sv - FETCH/EXEC/MEM/WB phase scheduler with wait states, bus handshake and timeout.
module sched_bus #(
    parameter int WAIT_W  = 4,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              err_clr,
    input  logic              need_mem,
    input  logic [WAIT_W-1:0] wait_cfg,
    sched_bus_if.master       bus,
    output logic              phf,
    output logic              phe,
    output logic              phm,
    output logic              phw,
    output logic [CNT_W-1:0]  icnt,
    output logic [2:0]        clk_stat
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    k_q, k_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic               err_q, err_d;

    logic in_bus_phase;
    logic waits_done;
    logic phase_done;
    logic phase_last;

    assign in_bus_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign waits_done   = {{WAIT_W{1'b0}}, k_q} > {{TO_W{1'b0}}, wait_q};
    assign phase_done   = in_bus_phase && waits_done && bus.bus_ready;
    assign phase_last   = k_q == TO_W'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wait_d  = wait_q;
        icnt_d  = icnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                    k_d     = TO_W'(1);
                    wait_d  = wait_cfg;
                end
            end
            S_FETCH, S_MEM: begin
                if (phase_done) begin
                    state_d = (state_q == S_FETCH) ? S_EXEC : S_WB;
                end else if (phase_last) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_EXEC: begin
                if (need_mem) begin
                    state_d = S_MEM;
                    k_d     = TO_W'(1);
                    wait_d  = wait_cfg;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                icnt_d = icnt_q + 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                    k_d     = TO_W'(1);
                    wait_d  = wait_cfg;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wait_q  <= '0;
            icnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            icnt_q  <= icnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode the registered state, so an async reset clears them without a clock edge.
    assign phf         = (state_q == S_FETCH) && waits_done && bus.bus_ready;
    assign phe         = (state_q == S_EXEC);
    assign phm         = (state_q == S_MEM) && waits_done && bus.bus_ready;
    assign phw         = (state_q == S_WB);
    assign bus.bus_req = in_bus_phase;
    assign bus.bus_err = err_q;
    assign icnt        = icnt_q;
    assign clk_stat    = state_q;

endmodule

// File: tb/tb_sched_bus.sv
// tb/tb_sched_bus.sv - scoreboard bench for sched_bus with a per-instruction reference model.
module tb_sched_bus;
    localparam int TIMEOUT = 200;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             err_clr = 1'b0;
    logic             need_mem = 1'b0;
    logic [3:0]       wait_cfg = 4'd0;
    logic             phf, phe, phm, phw;
    logic [CNT_W-1:0] icnt;
    logic [2:0]       clk_stat;

    sched_bus_if sb();

    sched_bus #(.WAIT_W(4), .TO_W(8), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .err_clr  (err_clr),
        .need_mem (need_mem),
        .wait_cfg (wait_cfg),
        .bus      (sb),
        .phf      (phf),
        .phe      (phe),
        .phm      (phm),
        .phw      (phw),
        .icnt     (icnt),
        .clk_stat (clk_stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ref_icnt = 0;
    int   breq_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int state_of(input int kind);
        return (kind == 0) ? 1 : (kind == 1) ? 2 : (kind == 2) ? 3 : 4;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.cnt  = ref_icnt;
        q.push_back(e);
        if (kind == 3) ref_icnt = (ref_icnt + 1) % (1 << CNT_W);
    endtask

    // Monitor: pops one expectation per observed strobe, flags missing or stray strobes.
    int   mon_n, mon_kind;
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (sb.bus_req) breq_cnt++;
            mon_n = int'(phf) + int'(phe) + int'(phm) + int'(phw);
            chk("strobe_onehot", int'(mon_n <= 1), 1);
            if (mon_n >= 1) begin
                mon_kind = phf ? 0 : phe ? 1 : phm ? 2 : 3;
                if (q.size() == 0) begin
                    chk("unexpected_strobe", mon_kind + 10, -1);
                end else begin
                    mon_e = q.pop_front();
                    chk("strobe_kind", mon_kind, mon_e.kind);
                    chk("strobe_cycle", cyc, mon_e.cyc);
                    chk("strobe_icnt", int'(icnt), mon_e.cnt);
                    chk("clk_stat_at_strobe", int'(clk_stat), state_of(mon_kind));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                chk("missing_strobe_kind", -1, mon_e.kind);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus phase: ready is random during wait cycles, then follows the ready-at-cycle-r plan.
    task automatic bus_phase(input int kind, input int w, input int r, output bit ok);
        ok = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            sb.bus_ready = (k <= w) ? 1'($urandom % 2) : (k >= r);
            if (k > w && sb.bus_ready) begin
                push(kind);
                ok = 1'b1;
            end
            #1;
            chk("bus_req_in_phase", int'(sb.bus_req), 1);
            chk("phase_state", int'(clk_stat), state_of(kind));
            tick();
            if (ok) break;
        end
        sb.bus_ready = 1'b0;
    endtask

    task automatic start_step(input int w);
        run = 1'b0;
        wait_cfg = 4'(w);
        step = 1'b1;
        #1 chk("idle_before_step", int'(clk_stat), 0);
        tick();
        step = 1'b0;
    endtask

    task automatic start_run(input int w);
        wait_cfg = 4'(w);
        run = 1'b1;
        #1 chk("idle_before_run", int'(clk_stat), 0);
        tick();
    endtask

    // Starts at the first FETCH cycle; ends one cycle after WB, or in ERR when ok=0.
    task automatic instr(input int wf, input int wm, input int rf, input int rm, input bit nm,
                         input bit run_next, input int w_next, input bit step_exec,
                         output bit ok, output int cycles);
        int start;
        start = cyc;
        cycles = 0;
        wait_cfg = 4'(wm);
        bus_phase(0, wf, rf, ok);
        if (!ok) return;
        need_mem = nm;
        step = step_exec;
        sb.bus_ready = 1'($urandom % 2);
        push(1);
        #1 chk("exec_bus_req", int'(sb.bus_req), 0);
        tick();
        step = 1'b0;
        need_mem = 1'($urandom % 2);
        if (nm) begin
            bus_phase(2, wm, rm, ok);
            if (!ok) return;
        end
        run = run_next;
        wait_cfg = 4'(w_next);
        sb.bus_ready = 1'($urandom % 2);
        push(3);
        #1 chk("wb_bus_req", int'(sb.bus_req), 0);
        tick();
        cycles = cyc - start;
    endtask

    task automatic err_recover();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.bus_ready = 1'($urandom % 2);
            #1;
            chk("err_state", int'(clk_stat), 5);
            chk("err_bus_err", int'(sb.bus_err), 1);
            chk("err_bus_req", int'(sb.bus_req), 0);
            tick();
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("err_clr_idle", int'(clk_stat), 0);
        chk("err_clr_bus_err", int'(sb.bus_err), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c, t0, ic, wf, wm, rf, rm, wn;
        bit nm, rn, chained;

        sb.bus_ready = 1'b0;
        #3;
        chk("rst_clk_stat", int'(clk_stat), 0);
        chk("rst_bus_req", int'(sb.bus_req), 0);
        chk("rst_bus_err", int'(sb.bus_err), 0);
        chk("rst_strobes", int'({phf, phe, phm, phw}), 0);
        chk("rst_icnt", int'(icnt), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Free run, no MEM, no waits.
        start_run(0);
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            instr(0, 0, 1, 1, 1'b0, i < 9, 0, 1'b0, ok, c);
            chk("free_run_len", c, 3);
        end
        #1;
        chk("free_run_icnt", int'(icnt), 10);
        chk("free_run_cycles", cyc - t0, 30);
        @(negedge clk);

        // MEM path with two wait states.
        start_step(2);
        breq_cnt = 0;
        instr(2, 2, 1, 1, 1'b1, 1'b0, 0, 1'b0, ok, c);
        chk("mem_instr_len", c, 8);
        chk("mem_bus_req_cycles", breq_cnt, 6);

        // Ready stall: ready arrives in FETCH cycle 6.
        start_step(0);
        instr(0, 0, 6, 1, 1'b0, 1'b0, 0, 1'b0, ok, c);
        chk("stall_instr_len", c, 8);

        // Timeout, then completion exactly in the last allowed cycle.
        start_step(0);
        instr(0, 0, TIMEOUT + 50, 1, 1'b0, 1'b0, 0, 1'b0, ok, c);
        err_recover();
        start_step(0);
        instr(0, 0, TIMEOUT, 1, 1'b0, 1'b0, 0, 1'b0, ok, c);
        chk("last_cycle_len", c, TIMEOUT + 2);

        // Single step with a stray step during EXEC.
        ic = ref_icnt;
        start_step(0);
        instr(0, 0, 1, 1, 1'b0, 1'b0, 0, 1'b1, ok, c);
        #1 chk("step_back_idle", int'(clk_stat), 0);
        @(negedge clk);
        #1;
        chk("step_stays_idle", int'(clk_stat), 0);
        chk("step_icnt", int'(icnt), (ic + 1) % 16);
        @(negedge clk);

        // Randomised mix of run/step, waits, stalls, MEM and occasional timeouts.
        chained = 1'b0;
        wn = $urandom % 4;
        for (int i = 0; i < 24; i++) begin
            wf = wn;
            if (!chained) begin
                if ($urandom % 2) start_run(wf);
                else start_step(wf);
            end
            wm = $urandom % 4;
            rf = ($urandom % 16 == 0) ? 255 : 1 + $urandom % 6;
            rm = ($urandom % 16 == 0) ? 255 : 1 + $urandom % 6;
            nm = 1'($urandom % 2);
            rn = (i < 23) && ($urandom % 2 == 1);
            wn = $urandom % 4;
            instr(wf, wm, rf, rm, nm, rn, wn, 1'($urandom % 2), ok, c);
            if (!ok) begin
                err_recover();
                chained = 1'b0;
            end else begin
                chained = rn;
            end
        end
        #1 chk("random_icnt", int'(icnt), ref_icnt);
        @(negedge clk);

        // Async reset in MEM cycle 2.
        start_step(0);
        wait_cfg = 4'd0;
        bus_phase(0, 0, 1, ok);
        need_mem = 1'b1;
        push(1);
        tick();
        sb.bus_ready = 1'b0;
        tick();
        sb.bus_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("amid_clk_stat", int'(clk_stat), 0);
        chk("amid_bus_req", int'(sb.bus_req), 0);
        chk("amid_strobes", int'({phf, phe, phm, phw}), 0);
        chk("amid_icnt", int'(icnt), 0);
        chk("amid_queue", q.size(), 0);
        ref_icnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Counter wrap.
        start_run(0);
        for (int i = 0; i < 16; i++) begin
            instr(0, 0, 1, 1, 1'($urandom % 2), i < 15, 0, 1'b0, ok, c);
        end
        #1 chk("icnt_wrap", int'(icnt), 0);
        @(negedge clk);
        @(negedge clk);
        #2 chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
